// File: rtl/sample_msg_combiner_pkg.sv
// Shared message definitions: header length field width, its extraction, and output FSM states.
package sample_msg_combiner_pkg;

    localparam int MSG_LENGTH_WIDTH = 8;
    localparam int MSG_MAX_WIDTH    = 64;

    typedef enum logic {
        IDLE,
        IN_MSG
    } out_state_e;

    // Length sits just below the header flag: hdr[width-2 -: MSG_LENGTH_WIDTH].
    function automatic logic [MSG_LENGTH_WIDTH-1:0] msg_length(
        input logic [MSG_MAX_WIDTH-1:0] hdr,
        input int                       width
    );
        return MSG_LENGTH_WIDTH'(hdr >> (width - 1 - MSG_LENGTH_WIDTH));
    endfunction

endpackage

// File: rtl/sample_msg_fifo.sv
// Synchronous FIFO with combinational read port so a word can be popped the cycle after it is written.
module sample_msg_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_rd;
    logic             do_wr;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign rd_data_o = mem[rd_ptr_q];

    // A write into a full FIFO still lands when the same cycle frees a slot.
    assign do_rd = rd_en_i && !empty_o;
    assign do_wr = wr_en_i && (!full_o || do_rd);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_q] <= wr_data_i;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/sample_msg_combiner.sv
// Merges a sample stream and a framed message stream into one output, never splitting a message.
// Optional input protocol checker enabled by SAMPLE_MSG_COMBINER_CHECK_EN.
module sample_msg_combiner
    import sample_msg_combiner_pkg::*;
#(
    parameter int WIDTH            = 32,
    parameter int SAMPLE_BUF_DEPTH = 16,
    parameter int MSG_BUF_DEPTH    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_samples,
    input  logic             in_samples_nd,
    input  logic [WIDTH-1:0] in_msg,
    input  logic             in_msg_nd,
    output logic [WIDTH-1:0] out_data,
    output logic             out_nd,
    output logic             error
);
    logic [WIDTH-1:0]            smp_rd_data;
    logic                        smp_empty, smp_full, smp_rd;
    logic [WIDTH-1:0]            msg_rd_data;
    logic                        msg_empty, msg_full, msg_rd;
    logic [MSG_LENGTH_WIDTH-1:0] hdr_len;

    out_state_e                  state_q, state_d;
    logic [MSG_LENGTH_WIDTH-1:0] remaining_q, remaining_d;
    logic [WIDTH-1:0]            out_data_q, out_data_d;
    logic                        out_nd_q, out_nd_d;
    logic                        error_q, error_d;
    logic                        overflow;
    logic                        proto_err;

    sample_msg_fifo #(.WIDTH(WIDTH), .DEPTH(SAMPLE_BUF_DEPTH)) u_smp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (in_samples_nd),
        .wr_data_i (in_samples),
        .rd_en_i   (smp_rd),
        .rd_data_o (smp_rd_data),
        .empty_o   (smp_empty),
        .full_o    (smp_full)
    );

    sample_msg_fifo #(.WIDTH(WIDTH), .DEPTH(MSG_BUF_DEPTH)) u_msg_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (in_msg_nd),
        .wr_data_i (in_msg),
        .rd_en_i   (msg_rd),
        .rd_data_o (msg_rd_data),
        .empty_o   (msg_empty),
        .full_o    (msg_full)
    );

    assign hdr_len = msg_length(MSG_MAX_WIDTH'(msg_rd_data), WIDTH);

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        out_data_d  = out_data_q;
        out_nd_d    = 1'b0;
        msg_rd      = 1'b0;
        smp_rd      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!msg_empty) begin
                    msg_rd      = 1'b1;
                    out_data_d  = msg_rd_data;
                    out_nd_d    = 1'b1;
                    remaining_d = hdr_len;
                    if (hdr_len != '0) state_d = IN_MSG;
                end else if (!smp_empty) begin
                    smp_rd     = 1'b1;
                    out_data_d = smp_rd_data;
                    out_nd_d   = 1'b1;
                end
            end
            IN_MSG: begin
                // Samples wait here even if the message stalls, so nothing interleaves a message.
                if (!msg_empty) begin
                    msg_rd      = 1'b1;
                    out_data_d  = msg_rd_data;
                    out_nd_d    = 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == MSG_LENGTH_WIDTH'(1)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign overflow = (in_samples_nd && smp_full && !smp_rd) ||
                      (in_msg_nd && msg_full && !msg_rd);

`ifdef SAMPLE_MSG_COMBINER_CHECK_EN
    logic [MSG_LENGTH_WIDTH-1:0] chk_rem_q, chk_rem_d;

    // Tracks how many content words the input side still owes for the current message.
    always_comb begin
        chk_rem_d = chk_rem_q;
        proto_err = 1'b0;
        if (in_samples_nd && in_samples[WIDTH-1]) proto_err = 1'b1;
        if (in_msg_nd) begin
            if (in_msg[WIDTH-1]) begin
                if (chk_rem_q != '0) proto_err = 1'b1;
                chk_rem_d = msg_length(MSG_MAX_WIDTH'(in_msg), WIDTH);
            end else if (chk_rem_q == '0) begin
                proto_err = 1'b1;
            end else begin
                chk_rem_d = chk_rem_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) chk_rem_q <= '0;
        else        chk_rem_q <= chk_rem_d;
    end
`else
    assign proto_err = 1'b0;
`endif

    assign error_d = error_q || overflow || proto_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            out_data_q  <= '0;
            out_nd_q    <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            out_data_q  <= out_data_d;
            out_nd_q    <= out_nd_d;
            error_q     <= error_d;
        end
    end

    assign out_data = out_data_q;
    assign out_nd   = out_nd_q;
    assign error    = error_q;

endmodule
